// File: rtl/alu_pkg.sv
// Shared op-codes and FSM encodings for the sequential logic/shift ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_SLL  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SRA) || (op == OP_SRL) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One iteration of the shifter: moves value by k bits (0..SHIFT_STEP).
module alu_shift_step #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1,
  parameter int KW         = $clog2(SHIFT_STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [KW-1:0]    k,
  input  logic             dir,    // 1 = right
  input  logic             arith,
  output logic [WIDTH-1:0] shifted
);

  // The MSB of an SRA value is always the original sign, so re-using it per step is exact.
  always_comb begin
    shifted = value;
    if (!dir)       shifted = value << k;
    else if (arith) shifted = $unsigned($signed(value) >>> k);
    else            shifted = value >> k;
  end

endmodule

// File: rtl/alu_seq_shift_logic.sv
// Multi-cycle logic/shift ALU: logic ops in one cycle, shifts SHIFT_STEP bits per cycle.
module alu_seq_shift_logic
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             op_err
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int KW      = $clog2(SHIFT_STEP + 1);
  localparam logic [SHAMT_W:0] STEP_V = (SHAMT_W + 1)'(SHIFT_STEP);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   val_q, val_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [2:0]         op_q, op_d;
  logic               out_valid_q, out_valid_d;
  logic               zero_q, zero_d;
  logic               op_err_q, op_err_d;

  logic [SHAMT_W-1:0] shamt_in;
  logic [SHAMT_W:0]   rem_ext, k_full;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   logic_res, shifted;
  logic               step_dir, step_arith;

  assign shamt_in   = in2[SHAMT_W-1:0];
  assign rem_ext    = {1'b0, rem_q};
  assign k_full     = (rem_ext < STEP_V) ? rem_ext : STEP_V;
  assign k          = k_full[KW-1:0];
  assign step_dir   = (op_q != OP_SLL);
  assign step_arith = (op_q == OP_SRA);

  alu_shift_step #(
    .WIDTH     (WIDTH),
    .SHIFT_STEP(SHIFT_STEP),
    .KW        (KW)
  ) u_step (
    .value  (val_q),
    .k      (k),
    .dir    (step_dir),
    .arith  (step_arith),
    .shifted(shifted)
  );

  // Shifts by zero and the reserved op both pass in1 through.
  always_comb begin
    case (op)
      OP_AND:  logic_res = in1 & in2;
      OP_OR:   logic_res = in1 | in2;
      OP_XOR:  logic_res = in1 ^ in2;
      OP_NOR:  logic_res = ~(in1 | in2);
      default: logic_res = in1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    val_d       = val_q;
    out_d       = out_q;
    rem_d       = rem_q;
    op_d        = op_q;
    out_valid_d = out_valid_q;
    zero_d      = zero_q;
    op_err_d    = op_err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d  = op;
          val_d = in1;
          rem_d = shamt_in;
          if (is_shift_op(op) && (shamt_in != '0)) begin
            state_d = ST_SHIFT;
          end else begin
            state_d     = ST_DONE;
            out_d       = logic_res;
            zero_d      = (logic_res == '0);
            op_err_d    = (op == OP_RSVD);
            out_valid_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        val_d = shifted;
        rem_d = rem_q - k_full[SHAMT_W-1:0];
        if (rem_ext == k_full) begin
          state_d     = ST_DONE;
          out_d       = shifted;
          zero_d      = (shifted == '0);
          op_err_d    = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      val_q       <= '0;
      out_q       <= '0;
      rem_q       <= '0;
      op_q        <= OP_AND;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      op_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      val_q       <= val_d;
      out_q       <= out_d;
      rem_q       <= rem_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      op_err_q    <= op_err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zero      = zero_q;
  assign op_err    = op_err_q;

endmodule
